bus_slave_connect_ctrl: RTL

Sequences the address phase of every granted transfer on the shared serial system bus and connects the granted master to the addressed slave. It sits between the bus arbiter and the slave-side read/write multiplexers. It watches `bus_grant`, shifts in the serial slave ID sent by the granted master, checks that ID and the target slave's readiness, then drives the one-hot slave enables and the return-path mux select. It holds the connection until the slave signals completion or the grant is withdrawn.

---
 rtl/bus_slave_connect_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bus_slave_connect_ctrl.sv
// Address-phase sequencer for the shared serial bus: captures the granted master's
// serial slave ID, checks it against slave readiness and connects the master to that slave.
module bus_slave_connect_ctrl #(
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_SLAVES = 3,
    parameter int TIMEOUT    = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [1:0]            bus_grant,
    input  logic                  m_valid,
    input  logic                  m_data,
    input  logic [NUM_SLAVES-1:0] slave_ready,
    input  logic [NUM_SLAVES-1:0] slave_done,
    output logic [NUM_SLAVES-1:0] slave_en,
    output logic [1:0]            mux_sel,
    output logic                  addr_ack,
    output logic                  addr_nack,
    output logic                  busy
);

    localparam int CW = $clog2(ADDR_WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CHECK,
        S_CONNECT,
        S_RELEASE
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_owner;
    logic [ADDR_WIDTH-1:0]   r_id;
    logic [CW-1:0]           r_bit_cnt;
    logic [TW-1:0]           r_tcnt;
    logic [NUM_SLAVES-1:0]   r_slave_en;
    logic [1:0]              r_mux_sel;
    logic                    r_ack;
    logic                    r_nack;
    logic                    r_busy;

    logic [NUM_SLAVES-1:0]   w_id_hot;
    logic                    w_id_valid;
    logic                    w_id_ready;
    logic                    w_id_done;
    logic                    w_grant_valid;
    logic                    w_abort;

    // IDs at or beyond NUM_SLAVES decode to all-zero, which doubles as the range check.
    function automatic logic [NUM_SLAVES-1:0] f_onehot(input logic [ADDR_WIDTH-1:0] id);
        logic [NUM_SLAVES-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            v[i] = (id == ADDR_WIDTH'(i));
        end
        return v;
    endfunction

    // Decode of the captured ID and the grant conditions used by the sequencer.
    always_comb begin
        w_id_hot      = f_onehot(r_id);
        w_id_valid    = |w_id_hot;
        w_id_ready    = |(slave_ready & w_id_hot);
        w_id_done     = |(slave_done & w_id_hot);
        w_grant_valid = (bus_grant == 2'b01) || (bus_grant == 2'b10);
        w_abort       = (bus_grant != r_owner);
    end

    // Address-phase sequencer with registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_owner    <= 2'b00;
            r_id       <= '0;
            r_bit_cnt  <= '0;
            r_tcnt     <= '0;
            r_slave_en <= '0;
            r_mux_sel  <= 2'b11;
            r_ack      <= 1'b0;
            r_nack     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ack  <= 1'b0;
            r_nack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner   <= bus_grant;
                        r_bit_cnt <= '0;
                        r_id      <= '0;
                        r_state   <= S_ADDR;
                        r_busy    <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (m_valid) begin
                        r_id      <= {r_id[ADDR_WIDTH-2:0], m_data};
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                        if (r_bit_cnt == CW'(ADDR_WIDTH - 1)) begin
                            r_state <= S_CHECK;
                            r_tcnt  <= '0;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (!w_id_valid) begin
                        r_nack  <= 1'b1;
                        r_state <= S_RELEASE;
                    end else if (w_id_ready) begin
                        r_slave_en <= w_id_hot;
                        r_mux_sel  <= 2'(r_id);
                        r_ack      <= 1'b1;
                        r_state    <= S_CONNECT;
                    end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                        r_nack  <= 1'b1;
                        r_state <= S_RELEASE;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_CONNECT: begin
                    if (w_abort) begin
                        r_slave_en <= '0;
                        r_mux_sel  <= 2'b11;
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                    end else if (w_id_done) begin
                        r_slave_en <= '0;
                        r_mux_sel  <= 2'b11;
                        r_state    <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // Grant must drop before the same master can start another transfer.
                    if (!w_grant_valid) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_slave_en <= '0;
                    r_mux_sel  <= 2'b11;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign slave_en  = r_slave_en;
    assign mux_sel   = r_mux_sel;
    assign addr_ack  = r_ack;
    assign addr_nack = r_nack;
    assign busy      = r_busy;

endmodule
